// File: rtl/irq_vector_ctl.sv
`default_nettype none
// ============================================================================
// Module   : irq_vector_ctl
// Purpose  : Fixed-priority vectored interrupt controller bridging up to four
//            irq/iack requesters to a CPU vector-fetch handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_vector_ctl #(
    parameter int         NDEV = 4,
    parameter logic [8:0] VEC0 = 9'o300,
    parameter logic [8:0] VEC1 = 9'o310,
    parameter logic [8:0] VEC2 = 9'o320,
    parameter logic [8:0] VEC3 = 9'o330,
    parameter logic [7:0] TMO  = 8'd255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic [NDEV-1:0] irq_i,
    output logic [NDEV-1:0] iack_o,
    input  logic            ien_i,
    output logic            cpu_virq_o,
    output logic [8:0]      cpu_ivec_o,
    input  logic            cpu_istb_i,
    output logic            cpu_ivld_o,
    output logic            cpu_ierr_o,
    output logic            busy_o
);

    localparam int SELW = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [NDEV-1:0] iack_q, iack_d;
    logic            virq_q, virq_d;
    logic [8:0]      ivec_q, ivec_d;
    logic            ivld_q, ivld_d;
    logic            ierr_q, ierr_d;
    logic            busy_q, busy_d;

    logic [8:0]      w_vec_tbl [NDEV];
    logic [SELW-1:0] w_enc;
    logic            w_req_any;
    logic            w_sel_irq;
    logic [7:0]      w_tmr_dec;
    logic            w_tmo;

    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_vec
            assign w_vec_tbl[gi] = (gi == 0) ? VEC0 :
                                   (gi == 1) ? VEC1 :
                                   (gi == 2) ? VEC2 : VEC3;
        end
    endgenerate

    // Lowest index wins: scan from the top so the last hit is the lowest bit.
    always_comb begin
        w_enc     = '0;
        w_req_any = |irq_i;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                w_enc = SELW'(i);
            end
        end
    end

    assign w_sel_irq = irq_i[sel_q];
    // Saturating decrement; the timeout fires when the decremented value hits 0.
    assign w_tmr_dec = (tmr_q == 8'd0) ? 8'd0 : tmr_q - 8'd1;
    assign w_tmo     = (w_tmr_dec == 8'd0);

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ien_i && w_req_any) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cpu_istb_i) begin
                    state_d = S_ACK;
                end else if (!w_sel_irq || !ien_i) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (!w_sel_irq || w_tmo) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!cpu_istb_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sel_d  = sel_q;
        tmr_d  = tmr_q;
        iack_d = iack_q;
        virq_d = virq_q;
        ivec_d = ivec_q;
        ivld_d = 1'b0;
        ierr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                iack_d = '0;
                virq_d = 1'b0;
                if (ien_i && w_req_any) begin
                    sel_d  = w_enc;
                    ivec_d = w_vec_tbl[w_enc];
                    virq_d = 1'b1;
                end
            end
            S_REQ: begin
                // Acceptance beats a withdraw seen in the same cycle.
                if (cpu_istb_i) begin
                    iack_d = {{(NDEV-1){1'b0}}, 1'b1} << sel_q;
                    virq_d = 1'b0;
                    tmr_d  = TMO;
                end else if (!w_sel_irq || !ien_i) begin
                    virq_d = 1'b0;
                end
            end
            S_ACK: begin
                tmr_d = w_tmr_dec;
                if (!w_sel_irq) begin
                    iack_d = '0;
                    ivld_d = 1'b1;
                end else if (w_tmo) begin
                    iack_d = '0;
                    ivld_d = 1'b1;
                    ierr_d = 1'b1;
                end
            end
            S_DONE: begin
                iack_d = '0;
            end
            default: begin
                iack_d = '0;
                virq_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sel_q  <= '0;
            tmr_q  <= '0;
            iack_q <= '0;
            virq_q <= 1'b0;
            ivec_q <= '0;
            ivld_q <= 1'b0;
            ierr_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            tmr_q  <= tmr_d;
            iack_q <= iack_d;
            virq_q <= virq_d;
            ivec_q <= ivec_d;
            ivld_q <= ivld_d;
            ierr_q <= ierr_d;
            busy_q <= busy_d;
        end
    end

    assign iack_o     = iack_q;
    assign cpu_virq_o = virq_q;
    assign cpu_ivec_o = ivec_q;
    assign cpu_ivld_o = ivld_q;
    assign cpu_ierr_o = ierr_q;
    assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_vector_ctl
// Purpose  : Directed and randomized self-checking bench for irq_vector_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_vector_ctl;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_r;
    logic [3:0] iack;
    logic       ien;
    logic       virq;
    logic [8:0] ivec;
    logic       istb;
    logic       ivld;
    logic       ierr;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] vec_m [4] = '{9'o300, 9'o310, 9'o320, 9'o330};
    logic [3:0] pend;

    irq_vector_ctl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .irq_i      (irq_r),
        .iack_o     (iack),
        .ien_i      (ien),
        .cpu_virq_o (virq),
        .cpu_ivec_o (ivec),
        .cpu_istb_i (istb),
        .cpu_ivld_o (ivld),
        .cpu_ierr_o (ierr),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // One complete, well-behaved transaction for the highest-priority pending device.
    task automatic serve(input bit add_extra);
        int         w;
        logic [3:0] oh;
        int         d;
        w  = lowest(pend);
        oh = 4'b0001 << w;
        irq_r = pend;
        step();
        chk("virq_rise", virq, 1);
        chk("ivec", ivec, vec_m[w]);
        chk("busy_req", busy, 1);
        chk("iack_req", iack, 0);
        d = $urandom_range(0, 3);
        repeat (d) begin
            step();
            chk("virq_hold", virq, 1);
            chk("iack_hold0", iack, 0);
        end
        istb = 1'b1;
        step();
        chk("iack_grant", iack, oh);
        chk("virq_fall", virq, 0);
        chk("ivec_ack", ivec, vec_m[w]);
        if (add_extra) begin
            pend  = pend | (4'($urandom_range(0, 15)) & ~oh);
            irq_r = pend;
        end
        d = $urandom_range(0, 4);
        repeat (d) begin
            step();
            chk("iack_keep", iack, oh);
            chk("ivld_early", ivld, 0);
        end
        pend  = pend & ~oh;
        irq_r = pend;
        step();
        chk("ivld_pulse", ivld, 1);
        chk("ierr_clear", ierr, 0);
        chk("iack_drop", iack, 0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            step();
            chk("ivld_once", ivld, 0);
            chk("busy_done", busy, 1);
        end
        istb = 1'b0;
        step();
        chk("busy_idle", busy, 0);
        chk("virq_idle", virq, 0);
        chk("ivld_idle", ivld, 0);
    endtask

    initial begin
        int n_srv;
        rst_n = 1'b0;
        irq_r = 4'b0000;
        ien   = 1'b0;
        istb  = 1'b0;
        pend  = 4'b0000;
        #12;
        chk("rst_iack", iack, 0);
        chk("rst_virq", virq, 0);
        chk("rst_ivec", ivec, 0);
        chk("rst_ivld", ivld, 0);
        chk("rst_ierr", ierr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        ien   = 1'b1;
        step();

        // Single request and then simultaneous requests served in priority order
        pend = 4'b0100;
        serve(1'b0);
        pend = 4'b1010;
        serve(1'b0);
        serve(1'b0);

        // Withdraw while the CPU has not yet accepted
        irq_r = 4'b0001;
        step();
        chk("wd_virq", virq, 1);
        irq_r = 4'b0000;
        step();
        chk("wd_virq_fall", virq, 0);
        chk("wd_busy", busy, 0);
        chk("wd_iack", iack, 0);
        chk("wd_ivld", ivld, 0);
        step();
        chk("wd_quiet", {iack, virq, ivld}, 0);

        // Timeout: the device never releases irq after iack
        irq_r = 4'b0010;
        step();
        chk("tmo_ivec", ivec, 9'o310);
        istb = 1'b1;
        step();
        chk("tmo_iack", iack, 4'b0010);
        repeat (254) begin
            step();
            chk("tmo_early", ivld, 0);
        end
        step();
        chk("tmo_ivld", ivld, 1);
        chk("tmo_ierr", ierr, 1);
        chk("tmo_iack_drop", iack, 0);
        step();
        chk("tmo_ivld_once", ivld, 0);
        chk("tmo_ierr_once", ierr, 0);
        istb = 1'b0;
        step();
        chk("tmo_idle", busy, 0);
        step();
        chk("tmo_rearb", virq, 1);
        chk("tmo_rearb_vec", ivec, 9'o310);
        istb = 1'b1;
        step();
        chk("tmo_rearb_iack", iack, 4'b0010);
        irq_r = 4'b0000;
        step();
        chk("tmo_rearb_ivld", ivld, 1);
        chk("tmo_rearb_ierr", ierr, 0);
        istb = 1'b0;
        step();

        // Masking, then irq drop racing cpu_istb_i in the same REQ cycle
        ien   = 1'b0;
        irq_r = 4'b0001;
        step();
        step();
        chk("mask_virq", virq, 0);
        chk("mask_busy", busy, 0);
        ien = 1'b1;
        step();
        chk("unmask_virq", virq, 1);
        chk("unmask_vec", ivec, 9'o300);
        irq_r = 4'b0000;
        istb  = 1'b1;
        step();
        chk("race_iack", iack, 4'b0001);
        chk("race_virq", virq, 0);
        step();
        chk("race_ivld", ivld, 1);
        istb = 1'b0;
        step();
        chk("race_idle", busy, 0);

        // Asynchronous reset in the middle of ACK
        irq_r = 4'b0001;
        step();
        istb = 1'b1;
        step();
        chk("ar_iack_pre", iack, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_iack", iack, 0);
        chk("ar_virq", virq, 0);
        chk("ar_busy", busy, 0);
        irq_r = 4'b0000;
        istb  = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk("ar_post_busy", busy, 0);
        chk("ar_post_ivld", ivld, 0);
        chk("ar_post_iack", iack, 0);

        // Randomized rounds: random request sets, late arrivals, masking gaps
        repeat (25) begin
            pend  = 4'($urandom_range(1, 15));
            irq_r = pend;
            n_srv = 0;
            while (pend != 4'b0000) begin
                if ($urandom_range(0, 3) == 0) begin
                    ien = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        step();
                        chk("rnd_mask", virq, 0);
                    end
                    ien = 1'b1;
                end
                serve((n_srv < 3) && ($urandom_range(0, 1) == 1));
                n_srv++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_vector_ctl.md
Name: irq_vector_ctl

Overview:
- Vectored interrupt controller that sits between the CPU core and up to four Wishbone peripherals.
- Each peripheral uses the irq/iack requester protocol:
  - the device raises irq;
  - the device drops irq when it sees iack;
  - the device waits for iack low before it can raise irq again.
- This block is the other end of that protocol. It arbitrates pending requests by fixed priority, presents the winner's vector to the CPU, drives the per-device iack, and detects devices that never release irq.

Parameters:
- NDEV, 4, number of requesters (fixed at 4 in this revision; index 0 is highest priority).
- VEC0, 9'o300, vector for device 0.
- VEC1, 9'o310, vector for device 1.
- VEC2, 9'o320, vector for device 2.
- VEC3, 9'o330, vector for device 3.
- TMO, 8'd255, number of cycles in ACK state without irq release before timeout.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- irq_i  in  4  interrupt requests from the devices (level).
- iack_o  out  4  interrupt acknowledges to the devices; at most one bit is set.
- ien_i  in  1  CPU interrupt enable (PSW priority permits); 0 blocks new arbitration.
- cpu_virq_o  out  1  vectored interrupt request to the CPU.
- cpu_ivec_o  out  9  vector of the granted device; stable from REQ through DONE.
- cpu_istb_i  in  1  CPU accepts the interrupt (level; held until cpu_ivld_o is seen).
- cpu_ivld_o  out  1  one-cycle pulse: vector fetch complete.
- cpu_ierr_o  out  1  one-cycle pulse, coincident with cpu_ivld_o, when the fetch completed by timeout.
- busy_o  out  1  state is not IDLE.

Behaviour:

Reset (async assert, sync release):
- State = IDLE, sel = 0, timer = 0.
- iack_o = 0, cpu_virq_o = 0, cpu_ivec_o = 0, cpu_ivld_o = 0, cpu_ierr_o = 0, busy_o = 0.
- Reset mid-transaction drops iack immediately. No completion pulse is produced.

States: IDLE, REQ, ACK, DONE (2-bit encoding).

IDLE:
- If ien_i=1 and irq_i != 0:
  - sel = index of the lowest set bit (priority encode);
  - cpu_ivec_o = VEC[sel];
  - cpu_virq_o = 1;
  - go to REQ.
- Latency from irq edge to cpu_virq_o is 1 cycle.
- Lower-priority requests arriving later do not change sel while not in IDLE. No preemption.

REQ:
- If cpu_istb_i=1: iack_o[sel] = 1, cpu_virq_o = 0, timer = TMO, go to ACK. This takes priority over the withdraw check in the same cycle.
- Else if irq_i[sel]=0 (device withdrew, e.g. its ie was cleared) or ien_i=0: cpu_virq_o = 0, go to IDLE. No iack is issued.

ACK:
- Each cycle, timer decrements.
- If irq_i[sel]=0:
  - iack_o = 0;
  - cpu_ivld_o = 1 for one cycle;
  - go to DONE.
- Else if timer = 0:
  - iack_o = 0;
  - cpu_ivld_o = 1 and cpu_ierr_o = 1 for one cycle;
  - go to DONE.
- cpu_istb_i dropping in ACK is ignored; the fetch always completes.

DONE:
- iack_o is already 0 here, so the device sees iack low and returns to idle.
- Stay until cpu_istb_i=0, then go to IDLE.
- Minimum 1 cycle in DONE, so at least one cycle of iack low precedes any new arbitration.

Other rules:
- Simultaneous requests: lowest index wins. The losers stay pending and are served in order by later transactions.
- busy_o = (state != IDLE), registered.
- Timer is 8 bits and must not wrap. Timeout fires exactly TMO cycles after ACK entry if irq is held.

Test Plan:
1. Single request: irq_i=4'b0100, ien_i=1 → next cycle cpu_virq_o=1, cpu_ivec_o=9'o320. Raise cpu_istb_i → iack_o=4'b0100. Device drops irq 2 cycles later → iack_o=0 and cpu_ivld_o pulse, cpu_ierr_o=0. Drop istb → IDLE.
2. Priority: irq_i=4'b1010 in the same cycle → vector 9'o310 and iack_o=4'b0010 first. After completion, the second transaction gives 9'o330 and iack_o=4'b1000.
3. Withdraw: irq_i[0] raised, then dropped while in REQ with cpu_istb_i=0 → cpu_virq_o falls, back to IDLE, iack_o never asserted, no ivld pulse.
4. Timeout: device holds irq_i[1]=1 forever after iack → exactly 255 cycles after ACK entry, cpu_ivld_o=cpu_ierr_o=1 for one cycle and iack_o=0. The held irq re-arbitrates after DONE.
5. Masking and race: ien_i=0 with irq_i=4'b0001 → no cpu_virq_o. Set ien_i=1 → request in 1 cycle. Then irq drop and cpu_istb_i rise in the same REQ cycle → goes to ACK with iack_o[0]=1.
6. Async reset mid-ACK: deassert wb_rst_n_i while iack_o=4'b0001 → iack_o, cpu_virq_o and busy_o go to 0 without waiting for a clock edge. After release, the state is IDLE.
